// File: rtl/rl_mod_exp_if.sv
// Start/operand/result bundle between the exponent-length stage and rl_mod_exp.
interface rl_mod_exp_if #(
    parameter int W  = 64,
    parameter int LW = 8
);
    logic          md_start;
    logic [W-1:0]  msg_in;
    logic [W-1:0]  exp_in;
    logic [W-1:0]  mod_in;
    logic [LW-1:0] len_in;
    logic [W-1:0]  res_out;
    logic          busy;
    logic          md_end;

    modport master (output md_start, msg_in, exp_in, mod_in, len_in,
                    input  res_out, busy, md_end);
    modport slave  (input  md_start, msg_in, exp_in, mod_in, len_in,
                    output res_out, busy, md_end);
endinterface

// File: rtl/rl_mod_exp.sv
// Right-to-left binary modular exponentiation, msg^exp mod N, built around one
// serial interleaved modular multiplier shared by the reduce, multiply and square steps.
module rl_mod_exp #(
    parameter int W  = 64,
    parameter int LW = 8
) (
    input  logic        clk,
    input  logic        rstn,
    rl_mod_exp_if.slave bus
);
    localparam int            IW       = $clog2(W);
    localparam logic [IW-1:0] CNT_TOP  = IW'(W - 1);
    localparam logic [LW-1:0] LEN_NONE = '1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RED, S_MUL, S_SQR, S_DONE} state_t;

    state_t        r_state;
    logic [W-1:0]  r_msg, r_exp, r_mod, r_R, r_B, r_res;
    logic [LW-1:0] r_len, r_i;
    logic [W+1:0]  r_P;
    logic [IW-1:0] r_cnt;
    logic          r_busy, r_end;

    logic [W-1:0]  w_opa, w_opb;
    logic          w_abit, w_last, w_ebit_cur, w_ebit_nxt;
    logic [W+1:0]  w_modx, w_p2, w_p3, w_p4;
    logic [LW-1:0] w_i_inc;

    // Operand A is scanned MSB first; B is the multiplicand added on set bits.
    always_comb begin
        w_opa = r_B;
        w_opb = r_B;
        if (r_state == S_RED) begin
            w_opa = r_msg;
            w_opb = W'(1);
        end else if (r_state == S_MUL) begin
            w_opa = r_R;
        end
        w_abit     = w_opa[r_cnt];
        w_last     = (r_cnt == '0);
        w_modx     = {2'b00, r_mod};
        w_p2       = (r_P << 1) + (w_abit ? {2'b00, w_opb} : {(W+2){1'b0}});
        w_p3       = (w_p2 >= w_modx) ? (w_p2 - w_modx) : w_p2;
        w_p4       = (w_p3 >= w_modx) ? (w_p3 - w_modx) : w_p3;
        w_i_inc    = r_i + LW'(1);
        w_ebit_cur = r_exp[r_i[IW-1:0]];
        w_ebit_nxt = r_exp[w_i_inc[IW-1:0]];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_msg   <= '0;
            r_exp   <= '0;
            r_mod   <= '0;
            r_len   <= '0;
            r_R     <= '0;
            r_B     <= '0;
            r_res   <= '0;
            r_i     <= '0;
            r_P     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_end   <= 1'b0;
        end else begin
            r_end <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.md_start) begin
                        r_msg   <= bus.msg_in;
                        r_exp   <= bus.exp_in;
                        r_mod   <= bus.mod_in;
                        r_len   <= bus.len_in;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_R   <= W'(1);
                    r_i   <= '0;
                    r_P   <= '0;
                    r_cnt <= CNT_TOP;
                    if (r_mod < W'(2)) begin
                        r_res   <= '0;
                        r_end   <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_len == LEN_NONE) begin
                        r_res   <= W'(1);
                        r_end   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_RED;
                    end
                end
                S_RED, S_MUL, S_SQR: begin
                    if (!w_last) begin
                        r_P   <= w_p4;
                        r_cnt <= r_cnt - IW'(1);
                    end else begin
                        // Next multiply starts on the very next cycle from a clean accumulator.
                        r_P   <= '0;
                        r_cnt <= CNT_TOP;
                        if (r_state == S_RED) begin
                            r_B <= w_p4[W-1:0];
                            if (w_ebit_cur) begin
                                r_state <= S_MUL;
                            end else if (r_len != '0) begin
                                r_state <= S_SQR;
                            end else begin
                                r_res   <= r_R;
                                r_end   <= 1'b1;
                                r_state <= S_DONE;
                            end
                        end else if (r_state == S_MUL) begin
                            r_R <= w_p4[W-1:0];
                            if (r_i < r_len) begin
                                r_state <= S_SQR;
                            end else begin
                                r_res   <= w_p4[W-1:0];
                                r_end   <= 1'b1;
                                r_state <= S_DONE;
                            end
                        end else begin
                            r_B <= w_p4[W-1:0];
                            r_i <= w_i_inc;
                            if (w_ebit_nxt) begin
                                r_state <= S_MUL;
                            end else if (w_i_inc < r_len) begin
                                r_state <= S_SQR;
                            end else begin
                                r_res   <= r_R;
                                r_end   <= 1'b1;
                                r_state <= S_DONE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.res_out = r_res;
    assign bus.busy    = r_busy;
    assign bus.md_end  = r_end;

endmodule
